// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: bundles the fetch requester, data requester and
// memory port of the unified-memory arbiter. The arbiter uses the slave
// modport; the surrounding system (core + memory) uses the master modport.
interface riscv_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    // data (load/store) requester
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // shared memory port
    logic              m_req;
    logic              m_we;
    logic [3:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    // status
    logic              busy;
    logic              err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_be, m_addr, m_wdata, busy, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_be, m_addr, m_wdata, busy, err
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch and
// data access. Alternates between the two when both are pending, registers
// all memory-side outputs and read data, and reports busy as a core stall.
// Optional macro ARB_TIMEOUT_EN: aborts an access after TIMEOUT_CYCLES wait
// cycles, returning 32'hDEAD_BEEF and setting a sticky err flag.
module riscv_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  clrn,
    riscv_mem_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

    state_t state;
    state_t state_next;
    logic   last_d;     // 1 when the most recent grant went to the data side
    logic   i_gnt;
    logic   d_gnt;
    logic   timeout;    // current access gives up this cycle

    assign bus.i_gnt = i_gnt;
    assign bus.d_gnt = d_gnt;
    assign bus.busy  = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count unacknowledged busy cycles; idle (and hence every grant) clears it.
    always_ff @(posedge clk) begin
        if (!clrn)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= '0;
        else if (!bus.m_ack)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // The last allowed wait cycle aborts unless memory acks in it (ack wins).
    assign timeout = (state != IDLE) && !bus.m_ack && (wait_cnt == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!clrn)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Grant selection and next state; data wins a tie unless it won last time.
    always_comb begin
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.d_req && (!bus.i_req || !last_d)) begin
                    d_gnt      = 1'b1;
                    state_next = BUSY_D;
                end else if (bus.i_req) begin
                    i_gnt      = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.m_ack || timeout)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory-side registers, response pulses and read data capture.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            last_d       <= 1'b0;
            bus.m_req    <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_be     <= 4'h0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            bus.d_rdata  <= '0;
            bus.err      <= 1'b0;
        end else begin
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.d_we;
                        bus.m_be    <= bus.d_we ? bus.d_be : 4'hF;
                        bus.m_addr  <= bus.d_addr;
                        bus.m_wdata <= bus.d_wdata;
                        last_d      <= 1'b1;
                    end else if (i_gnt) begin
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= 1'b0;
                        bus.m_be    <= 4'hF;
                        bus.m_addr  <= bus.i_addr;
                        last_d      <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (bus.m_ack) begin
                        bus.m_req    <= 1'b0;
                        bus.i_rvalid <= 1'b1;
                        bus.i_rdata  <= bus.m_rdata;
                    end else if (timeout) begin
                        bus.m_req    <= 1'b0;
                        bus.i_rvalid <= 1'b1;
                        bus.i_rdata  <= ABORT_DATA;
                        bus.err      <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (bus.m_ack) begin
                        bus.m_req    <= 1'b0;
                        bus.d_rvalid <= 1'b1;
                        // a store completion leaves the last load data in place
                        if (!bus.m_we)
                            bus.d_rdata <= bus.m_rdata;
                    end else if (timeout) begin
                        bus.m_req    <= 1'b0;
                        bus.d_rvalid <= 1'b1;
                        bus.d_rdata  <= ABORT_DATA;
                        bus.err      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: scoreboard bench for the fetch/data memory arbiter.
// Grants push the expected response; rvalid pulses pop and compare it.
module tb_riscv_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit          is_d;
        bit          is_store;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] last_dload = '0;

    // memory model controls
    int wait_cfg  = 0;
    bit mem_en    = 1'b1;
    bit stray_ack = 1'b0;
    bit tmo_mode  = 1'b0;
    int wcnt      = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0000);
    endfunction

    // Memory: acks after wait_cfg wait cycles while m_req is high.
    always @(negedge clk) begin
        if (stray_ack) begin
            bus.m_ack   = 1'b1;
            bus.m_rdata = 32'h1234_5678;
        end else if (!bus.m_req) begin
            bus.m_ack = 1'b0;
            wcnt      = 0;
        end else if (mem_en && wcnt >= wait_cfg) begin
            bus.m_ack   = 1'b1;
            bus.m_rdata = mem_data(bus.m_addr);
        end else begin
            bus.m_ack = 1'b0;
            wcnt++;
        end
    end

    // Scoreboard: compare responses against queue, push on grants.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] want;
        if (bus.i_rvalid || bus.d_rvalid) begin
            checks++;
            if (sbq.size() == 0) begin
                $display("FAIL sb_unexpected_rvalid got i_rvalid=%0b d_rvalid=%0b want no response",
                         bus.i_rvalid, bus.d_rvalid);
            end else begin
                e = sbq.pop_front();
                if (e.is_d) begin
                    want = e.is_store ? last_dload : e.data;
                    if (!bus.d_rvalid || bus.i_rvalid || bus.d_rdata !== want)
                        $display("FAIL sb_data_resp got d_rvalid=%0b i_rvalid=%0b d_rdata=%h want d_rvalid=1 d_rdata=%h",
                                 bus.d_rvalid, bus.i_rvalid, bus.d_rdata, want);
                    else
                        passes++;
                    if (!e.is_store) last_dload = e.data;
                end else begin
                    if (!bus.i_rvalid || bus.d_rvalid || bus.i_rdata !== e.data)
                        $display("FAIL sb_fetch_resp got i_rvalid=%0b d_rvalid=%0b i_rdata=%h want i_rvalid=1 i_rdata=%h",
                                 bus.i_rvalid, bus.d_rvalid, bus.i_rdata, e.data);
                    else
                        passes++;
                end
            end
        end
        if (clrn && bus.d_gnt)
            sbq.push_back('{is_d: 1'b1, is_store: (bus.d_we && !tmo_mode),
                            data: tmo_mode ? 32'hDEAD_BEEF : mem_data(bus.d_addr)});
        if (clrn && bus.i_gnt)
            sbq.push_back('{is_d: 1'b0, is_store: 1'b0,
                            data: tmo_mode ? 32'hDEAD_BEEF : mem_data(bus.i_addr)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    // Wait (bounded) for all expected responses and an idle arbiter.
    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (sbq.size() == 0 && !bus.busy && !bus.i_rvalid && !bus.d_rvalid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!done) $display("FAIL %s_drain got pending=%0d busy=%0b want drained", name, sbq.size(), bus.busy);
        else passes++;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sbq.delete();
        last_dload = '0;
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_be = '0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.m_ack = 0; bus.m_rdata = '0;
        clrn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_be, bus.i_rvalid, bus.d_rvalid, bus.err, bus.busy, bus.i_gnt, bus.d_gnt} !== 12'h0)
            $display("FAIL reset_ctrl got m_req=%0b m_we=%0b m_be=%h iv=%0b dv=%0b err=%0b busy=%0b want all 0",
                     bus.m_req, bus.m_we, bus.m_be, bus.i_rvalid, bus.d_rvalid, bus.err, bus.busy);
        else passes++;
        checks++;
        if ({bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 128'h0)
            $display("FAIL reset_data got m_addr=%h m_wdata=%h i_rdata=%h d_rdata=%h want 0",
                     bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata);
        else passes++;
        @(posedge clk); #1;
        clrn = 1'b1;
    endtask

    task automatic test_fetch();
        wait_cfg = 0;
        bus.i_addr = 32'h0; bus.i_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.i_gnt, bus.d_gnt, bus.busy} !== 3'b100)
            $display("FAIL fetch_c0 got i_gnt=%0b d_gnt=%0b busy=%0b want 1 0 0", bus.i_gnt, bus.d_gnt, bus.busy);
        else passes++;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.m_req, bus.busy, bus.m_we, bus.m_be} !== 7'b1101111 || bus.m_addr !== 32'h0)
            $display("FAIL fetch_c1 got m_req=%0b busy=%0b m_we=%0b m_be=%h m_addr=%h want 1 1 0 f 0",
                     bus.m_req, bus.busy, bus.m_we, bus.m_be, bus.m_addr);
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.i_rvalid, bus.busy, bus.m_req} !== 3'b100 || bus.i_rdata !== 32'h0000_0013)
            $display("FAIL fetch_c2 got i_rvalid=%0b busy=%0b m_req=%0b i_rdata=%h want 1 0 0 00000013",
                     bus.i_rvalid, bus.busy, bus.m_req, bus.i_rdata);
        else passes++;
        @(posedge clk); #1;
        wait_drain("fetch");
    endtask

    task automatic test_alternate();
        bit [3:0] seq = '0;
        int       n   = 0;
        bit       excl_ok = 1'b1;
        wait_cfg = 0;
        bus.i_addr = 32'h200; bus.d_addr = 32'h300; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if ((bus.i_gnt && bus.d_gnt) || ((bus.i_gnt || bus.d_gnt) && bus.busy)) excl_ok = 1'b0;
            if (bus.d_gnt) begin seq[n] = 1'b1; n++; end
            else if (bus.i_gnt) begin seq[n] = 1'b0; n++; end
            @(posedge clk); #1;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        checks++;
        if (n != 4 || seq !== 4'b0101)
            $display("FAIL alt_order got grants=%0d seq(lsb first)=%b want 4 grants 0101 (D,I,D,I)", n, seq);
        else passes++;
        checks++;
        if (!excl_ok) $display("FAIL alt_exclusive got overlapping or busy grant want single idle grant");
        else passes++;
        wait_drain("alt");
    endtask

    task automatic test_store();
        int          hi = 0;
        bit          stable = 1'b1;
        logic [31:0] prev;
        prev = last_dload;
        wait_cfg = 3;
        bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h100; bus.d_wdata = 32'hAABB_CCDD;
        bus.d_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.d_gnt !== 1'b1) $display("FAIL store_gnt got d_gnt=%0b want 1", bus.d_gnt);
        else passes++;
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_wdata = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.m_req) hi++;
            if ({bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata} !== {1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD} || bus.d_rvalid)
                stable = 1'b0;
        end
        checks++;
        if (hi != 4 || !stable)
            $display("FAIL store_hold got m_req_cycles=%0d stable=%0b want 4 1", hi, stable);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.m_req !== 1'b0 || bus.d_rdata !== prev)
            $display("FAIL store_done got d_rvalid=%0b m_req=%0b d_rdata=%h want 1 0 %h",
                     bus.d_rvalid, bus.m_req, bus.d_rdata, prev);
        else passes++;
        @(posedge clk); #1;
        wait_drain("store");
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bit got  = 1'b0;
        wait_cfg = 10;
        bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.d_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.d_gnt !== 1'b1) $display("FAIL rstmid_gnt got d_gnt=%0b want 1", bus.d_gnt);
        else passes++;
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        clrn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_req !== 1'b1) $display("FAIL rstmid_waiting got m_req=%0b want 1", bus.m_req);
        else passes++;
        @(posedge clk); #1;
        clrn = 1'b1;
        sbq.delete();
        last_dload = '0;
        @(negedge clk);
        checks++;
        if ({bus.m_req, bus.busy, bus.d_rvalid} !== 3'b000 || bus.d_rdata !== 32'h0)
            $display("FAIL rstmid_after got m_req=%0b busy=%0b d_rvalid=%0b d_rdata=%h want 0 0 0 0",
                     bus.m_req, bus.busy, bus.d_rvalid, bus.d_rdata);
        else passes++;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.d_rvalid) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL rstmid_no_rvalid got d_rvalid pulse want none");
        else passes++;
        @(posedge clk); #1;
        wait_cfg = 1;
        bus.i_addr = 32'h44; bus.i_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.i_gnt) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        checks++;
        if (!got) $display("FAIL rstmid_refetch got no i_gnt want i_gnt");
        else passes++;
        wait_drain("rstmid");
    endtask

    task automatic test_back_to_back();
        wait_cfg = 0;
        bus.i_addr = 32'h80; bus.i_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.i_gnt !== 1'b1) $display("FAIL b2b_gnt0 got i_gnt=%0b want 1", bus.i_gnt);
        else passes++;
        @(posedge clk); #1;
        bus.i_addr = 32'h84;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.i_rvalid !== 1'b1 || bus.i_gnt !== 1'b1)
            $display("FAIL b2b_overlap got i_rvalid=%0b i_gnt=%0b want 1 1", bus.i_rvalid, bus.i_gnt);
        else passes++;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        wait_drain("b2b");
    endtask

    task automatic test_stray_ack();
        bit bad = 1'b0;
        stray_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.busy || bus.m_req || bus.i_rvalid || bus.d_rvalid) bad = 1'b1;
        end
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(negedge clk);
        if (bus.i_rvalid || bus.d_rvalid) bad = 1'b1;
        checks++;
        if (bad) $display("FAIL stray_ack got activity on idle ack want none");
        else passes++;
        @(posedge clk); #1;
    endtask

    // Issue one load and return cycles from grant to d_rvalid (-1 if none).
    task automatic issue_load(input logic [31:0] addr, output int lat);
        lat = -1;
        bus.d_we = 1'b0; bus.d_addr = addr; bus.d_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (bus.d_rvalid) begin lat = c; break; end
        end
        @(posedge clk); #1;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        wait_cfg = 3;
        issue_load(32'h600, lat);
        checks++;
        if (lat != 5 || bus.err !== 1'b0)
            $display("FAIL tmo_ack_last got latency=%0d err=%0b want 5 0", lat, bus.err);
        else passes++;
        wait_drain("tmo_ack");
        mem_en = 1'b0; tmo_mode = 1'b1;
        issue_load(32'h640, lat);
        checks++;
        if (lat != 5 || bus.err !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL tmo_abort got latency=%0d err=%0b busy=%0b want 5 1 0", lat, bus.err, bus.busy);
        else passes++;
        mem_en = 1'b1; tmo_mode = 1'b0;
        wait_drain("tmo_abort");
        wait_cfg = 0;
        issue_load(32'h680, lat);
        wait_drain("tmo_after");
        checks++;
        if (bus.err !== 1'b1) $display("FAIL tmo_sticky got err=%0b want 1", bus.err);
        else passes++;
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) $display("FAIL tmo_clear got err=%0b want 0", bus.err);
        else passes++;
        @(posedge clk); #1;
    endtask
`else
    task automatic test_timeout();
        bit bad = 1'b0;
        wait_cfg = 0;
        mem_en = 1'b0;
        bus.d_we = 1'b0; bus.d_addr = 32'h700; bus.d_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!bus.busy || !bus.m_req || bus.d_rvalid || bus.err) bad = 1'b1;
        end
        checks++;
        if (bad) $display("FAIL no_tmo_wait got early completion or err want indefinite wait");
        else passes++;
        @(posedge clk); #1;
        mem_en = 1'b1;
        wait_drain("no_tmo");
        checks++;
        if (bus.err !== 1'b0) $display("FAIL no_tmo_err got err=%0b want 0", bus.err);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_alternate();
        test_store();
        test_reset_mid();
        test_back_to_back();
        test_stray_ack();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares one memory port between the CPU's instruction-fetch requester and data (load/store) requester, for unified-memory builds of the RV32I core. Each requester uses a req/gnt/rvalid handshake; the memory side uses req/ack with variable wait states. When both requesters are pending, the arbiter alternates between them. It registers all memory-side outputs and read data, and exposes a busy flag that the core uses as a stall.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, wait-state limit before abort (used only with ARB_TIMEOUT_EN); counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock; all state updates on the rising edge
clrn  in  1  synchronous active-low reset, sampled on the rising edge of clk
i_req  in  1  instruction fetch request; held until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  DATA_W  fetched instruction word
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_be  in  4  store byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
d_rdata  out  DATA_W  load data
m_req  out  1  memory request; held until m_ack
m_we  out  1  memory write
m_be  out  4  memory byte enables (4'hF for fetch and load)
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_ack  in  1  memory completes the current request this cycle
m_rdata  in  DATA_W  memory read data, valid when m_ack = 1
busy  out  1  1 when state is not IDLE
err  out  1  timeout flag (see Optional Feature); tied to 0 when the feature is off

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset (clrn = 0 at a clock edge):
  - state goes to IDLE; last_d clears to 0.
  - All outputs clear to 0: m_req, m_we, m_be, m_addr, m_wdata, i_rvalid, d_rvalid, i_rdata, d_rdata, err.
  - Reset mid-transaction drops the outstanding access. No rvalid is issued for it. m_req is low from the first cycle after that edge.
- IDLE, grant selection (combinational):
  - Only d_req: d_gnt = 1.
  - Only i_req: i_gnt = 1.
  - Both: grant data if last_d = 0, otherwise grant instruction.
  - At most one gnt is high in any cycle. gnt is high only in IDLE.
- On a grant edge:
  - Latch the selected requester's address, we, be and wdata into the m_* registers. Fetch forces m_we = 0 and m_be = 4'hF. A load forces m_be = 4'hF.
  - Set m_req = 1.
  - last_d <= 1 on a data grant, 0 on an instruction grant.
  - Go to BUSY_D or BUSY_I.
- BUSY_x:
  - m_* registers are held stable while m_ack = 0.
  - On the m_ack edge: m_req <= 0; state <= IDLE; x_rvalid <= 1 for exactly one cycle.
  - x_rdata <= m_rdata for fetches and loads. d_rdata holds its previous value on a store ack.
- Latency (grant at edge N, where edge N ends the cycle in which gnt is high):
  - m_req is high in the cycle after edge N.
  - A zero-wait memory (m_ack = 1 in that first m_req cycle) gives x_rvalid in the cycle after edge N+1.
  - Each wait cycle adds 1.
- Back-to-back: the cycle after the ack edge is IDLE, so a new grant can coincide with the rvalid pulse of the previous access.
- m_ack while state is IDLE is ignored.
- i_rdata and d_rdata hold their values between responses.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A wait counter clears on each grant and increments in every BUSY_x cycle without m_ack.
  - When it reaches TIMEOUT_CYCLES: m_req <= 0, state <= IDLE, x_rvalid pulses with x_rdata = 32'hDEAD_BEEF, and err <= 1.
  - err is sticky until reset.
  - An m_ack arriving in the same cycle as the timeout wins: normal completion, no err.
- Undefined: no counter, err is constant 0, and the arbiter waits indefinitely for m_ack.

Test Plan:
- Reset, then i_req = 1, i_addr = 0x0000_0000, memory acks in the first m_req cycle returning 0x0000_0013 -> i_gnt in cycle 0, m_req/m_addr = 0 in cycle 1, i_rvalid = 1 with i_rdata = 0x0000_0013 in cycle 2, busy = 1 in cycle 1 only.
- d_req = 1 and i_req = 1 simultaneously after reset -> data granted first; next IDLE grants instruction; with both held, grants alternate D, I, D, I.
- Store d_we = 1, d_be = 4'b0011, d_addr = 0x100, d_wdata = 0xAABB_CCDD, with 3 wait cycles -> m_* stable for 4 cycles, m_be = 0011; d_rvalid one cycle after ack; d_rdata unchanged.
- Assert clrn = 0 in the second wait cycle of a load -> m_req = 0 and busy = 0 in the next cycle; no d_rvalid; a new i_req after reset is granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, memory never acks -> d_rvalid with 0xDEAD_BEEF after 4 BUSY cycles, err = 1 and stays 1; ack on the 4th cycle -> normal data, err = 0.
